// File: rtl/vga_if.sv
// Video timing bundle shared between the timing generator and its consumers.
// Signals:
//   hcount[10:0], vcount[10:0] : current pixel position
//   hblnk, vblnk               : horizontal / vertical blanking
//   hsync, vsync               : sync pulses (polarity set by the producer)
// Modports: out (producer), in (consumer).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;

    modport out (output hcount, output vcount, output hblnk, output vblnk,
                 output hsync, output vsync);
    modport in  (input  hcount, input  vcount, input  hblnk, input  vblnk,
                 input  hsync, input  vsync);
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Produces pixel/line counters, blanking and sync for a configurable video mode.
// Every output is a register loaded from the next-state counter values, so all
// outputs in a cycle describe the same (hcount, vcount) pair.
// Ports:
//   clk         : pixel clock
//   rst         : synchronous active-high reset
//   vga_out     : vga_if.out bundle (hcount, vcount, hblnk, vblnk, hsync, vsync)
//   frame_start : one-cycle pulse when the outputs show pixel (0,0)
//   frame_cnt   : completed-frame counter, only when VGA_TIMING_FRAME_CNT_EN is defined
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module vga_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned SYNC_POS = 1
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.out          vga_out,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLANK  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_BLANK  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ACT = (SYNC_POS != 0);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;

    // Next raster position and the decode of that position.
    always_comb begin
        hcount_d = hcount_q + CNT_W'(1);
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
        end

        hblnk_d       = (hcount_d >= H_BLANK);
        vblnk_d       = (vcount_d >= V_BLANK);
        hsync_d       = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
        vsync_d       = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
        // Only reachable by wrapping from the last pixel, never from reset.
        frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end

    // Output registers; reset parks the raster at (0,0) with sync inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign frame_start    = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Advances on the same edge frame_start is raised; wraps naturally at 2^16.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL expose the following parameters, one per line as name, default, meaning:
- H_ACTIVE, 800, visible pixels per line.
- H_FP, 40, horizontal front porch.
- H_SYNC, 128, horizontal sync width.
- H_BP, 88, horizontal back porch.
- V_ACTIVE, 600, visible lines.
- V_FP, 1, vertical front porch.
- V_SYNC, 4, vertical sync width.
- V_BP, 23, vertical back porch.
- SYNC_POS, 1, sync polarity (1 = active-high).

REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk, input, 1, pixel clock (40 MHz for the defaults).
- rst, input, 1, reset; synchronous, active-high; clock is clk.
- vga_out, vga_if.out modport, n/a, hcount[10:0], vcount[10:0], hblnk, vblnk, hsync, vsync.
- frame_start, output, 1, single-cycle pulse at pixel (0,0).
- frame_cnt, output, 16, frames completed (present only with the macro in REQ-019).

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
REQ-004 All outputs SHALL be registered on posedge clk, with no combinational path from any input to any output.
REQ-005 hcount SHALL increment by 1 every cycle and wrap from H_TOTAL-1 to 0.
REQ-006 vcount SHALL increment by 1 on the cycle hcount wraps, and SHALL hold otherwise.
REQ-007 vcount SHALL wrap from V_TOTAL-1 to 0 only on the same cycle hcount wraps.
REQ-008 hblnk SHALL be 1 exactly when the output hcount is in [H_ACTIVE, H_TOTAL-1].
REQ-009 vblnk SHALL be 1 exactly when the output vcount is in [V_ACTIVE, V_TOTAL-1].
REQ-010 hsync SHALL be active exactly when hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (defaults 840..967).
REQ-011 vsync SHALL be active exactly when vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (defaults 601..604).
REQ-012 Sync "active" SHALL mean 1 when SYNC_POS=1 and 0 when SYNC_POS=0; inactive is the opposite level.
REQ-013 hblnk, vblnk, hsync and vsync SHALL be derived from the next-state counter values, so that every output in a given cycle refers to the same (hcount, vcount) pair, with zero skew.
REQ-014 frame_start SHALL be 1 for exactly one cycle, in the cycle the outputs show hcount=0 and vcount=0, and 0 at all other times.
REQ-015 The counters SHALL be 11 bits wide, and all range comparisons SHALL be unsigned with no truncation for any parameter set where H_TOTAL and V_TOTAL are at most 2047.

Reset
REQ-016 While rst=1, at every posedge the block SHALL drive hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, frame_cnt=0, and hsync/vsync at their inactive level.
REQ-017 On the first posedge with rst=0, the outputs SHALL show hcount=1, vcount=0.
REQ-018 Assertion of rst mid-frame SHALL abort the frame on the next edge, with no partial sync pulse extended beyond the reset edge; frame_start SHALL NOT pulse for the reset state.

Configuration
REQ-019 When macro VGA_TIMING_FRAME_CNT_EN is defined, the frame_cnt port SHALL exist and SHALL increment by 1 (mod 2^16, wrapping 65535 to 0) on the same edge frame_start rises.
REQ-020 When VGA_TIMING_FRAME_CNT_EN is undefined, the frame_cnt port and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset 5 cycles then release -> first post-reset output is hcount=1, vcount=0; sync inactive; blanks 0.
- Run one line -> hblnk rises at hcount=800 and falls at 0; hsync is active for 128 cycles from hcount=840; the wrap after 1055 gives vcount=1.
- Run one full frame (663168 cycles) -> vsync is active on lines 601..604 only; vblnk spans lines 600..627; frame_start pulses once at (0,0).
- Assert rst at hcount=900, vcount=602 for 1 cycle -> next outputs are all zero/inactive; counting restarts; no stray frame_start.
- With VGA_TIMING_FRAME_CNT_EN defined, run 3 frames -> frame_cnt=3; preload is not possible, so force the internal register to 65535 and cross a frame -> frame_cnt=0.
- Set SYNC_POS=0 and run one line -> hsync is 0 during hcount 840..967 and 1 elsewhere.
